// File: rtl/pic_pkg.sv
// Shared definitions for the 8259-style PIC: decode FSM states,
// flag bit positions and read-select codes.
package pic_pkg;

   typedef enum logic [2:0] {
      UNINIT    = 3'd0,
      WAIT_ICW2 = 3'd1,
      WAIT_ICW3 = 3'd2,
      WAIT_ICW4 = 3'd3,
      READY     = 3'd4
   } pic_state_t;

   localparam int ICW1_BIT = 0;
   localparam int ICW2_BIT = 1;
   localparam int ICW3_BIT = 2;
   localparam int ICW4_BIT = 3;

   localparam int OCW1_BIT = 0;
   localparam int OCW2_BIT = 1;
   localparam int OCW3_BIT = 2;

   localparam logic [1:0] RC_ISR = 2'b11;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer for an asynchronous strobe plus a rising-edge
// detector on the synchronized level. All flops reset to 1 (strobe idle).
module sync_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise
);

   logic s1, s2, s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync = s2;
   assign rise = s2 & ~s3;

endmodule

// File: rtl/read_write_logic.sv
// CPU bus interface of the PIC: samples writes on the synchronized WR_n
// rising edge, decodes ICW/OCW sequence, and muxes register readback.
module read_write_logic (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       CS_n,
   input  logic       WR_n,
   input  logic       RD_n,
   input  logic       A0,
   input  logic [7:0] D_IN,
   input  logic [7:0] IRR,
   input  logic [7:0] ISR,
   input  logic [7:0] IMR,
   input  logic [1:0] Read_command,
   output logic [7:0] DATA_OUT,
   output logic [3:0] ICWs_Flags,
   output logic [2:0] OCWs_Flags,
   output logic [7:0] D_OUT,
   output logic       D_OE
);
   import pic_pkg::*;

   logic       wr_sync, wr_rise;
   logic       cap_cs_n, cap_a0;
   logic [7:0] cap_d;

   pic_state_t state, state_nxt;
   logic       sngl, ic4, sngl_nxt, ic4_nxt;
   logic [3:0] icw_nxt;
   logic [2:0] ocw_nxt;

   sync_rise u_wr_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (WR_n),
      .sync (wr_sync),
      .rise (wr_rise)
   );

   // Bus fields are sampled every cycle the strobe is low; the last sample wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_cs_n <= 1'b0;
         cap_a0   <= 1'b0;
         cap_d    <= 8'h00;
      end else if (!wr_sync) begin
         cap_cs_n <= CS_n;
         cap_a0   <= A0;
         cap_d    <= D_IN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= UNINIT;
         sngl       <= 1'b0;
         ic4        <= 1'b0;
         ICWs_Flags <= 4'h0;
         OCWs_Flags <= 3'h0;
         DATA_OUT   <= 8'h00;
      end else begin
         state      <= state_nxt;
         sngl       <= sngl_nxt;
         ic4        <= ic4_nxt;
         ICWs_Flags <= icw_nxt;
         OCWs_Flags <= ocw_nxt;
         if ((|icw_nxt) || (|ocw_nxt))
            DATA_OUT <= cap_d;
      end
   end

   always_comb begin
      state_nxt = state;
      sngl_nxt  = sngl;
      ic4_nxt   = ic4;
      icw_nxt   = 4'h0;
      ocw_nxt   = 3'h0;
      if (wr_rise && !cap_cs_n) begin
         // ICW1 restarts initialization from any state.
         if (!cap_a0 && cap_d[4]) begin
            icw_nxt[ICW1_BIT] = 1'b1;
            sngl_nxt          = cap_d[1];
            ic4_nxt           = cap_d[0];
            state_nxt         = WAIT_ICW2;
         end else begin
            case (state)
               WAIT_ICW2: if (cap_a0) begin
                  icw_nxt[ICW2_BIT] = 1'b1;
                  state_nxt = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
               end
               WAIT_ICW3: if (cap_a0) begin
                  icw_nxt[ICW3_BIT] = 1'b1;
                  state_nxt = ic4 ? WAIT_ICW4 : READY;
               end
               WAIT_ICW4: if (cap_a0) begin
                  icw_nxt[ICW4_BIT] = 1'b1;
                  state_nxt = READY;
               end
               READY: begin
                  if (cap_a0)
                     ocw_nxt[OCW1_BIT] = 1'b1;
                  else if (!cap_d[3])
                     ocw_nxt[OCW2_BIT] = 1'b1;
                  else
                     ocw_nxt[OCW3_BIT] = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign D_OE  = !CS_n && !RD_n;
   assign D_OUT = !D_OE ? 8'h00 :
                  A0    ? IMR   :
                  (Read_command == RC_ISR) ? ISR : IRR;

endmodule

// File: tb/tb_read_write_logic.sv
// Bench for read_write_logic: directed vector table, hand sequences for
// reads and reset corners, and randomized writes/reads against a model.
module tb_read_write_logic;

   logic       clk, rst_n, CS_n, WR_n, RD_n, A0;
   logic [7:0] D_IN, IRR, ISR, IMR;
   logic [1:0] Read_command;
   logic [7:0] DATA_OUT, D_OUT;
   logic [3:0] ICWs_Flags;
   logic [2:0] OCWs_Flags;
   logic       D_OE;

   int checks = 0;
   int errors = 0;

   read_write_logic dut (
      .clk(clk), .rst_n(rst_n), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n),
      .A0(A0), .D_IN(D_IN), .IRR(IRR), .ISR(ISR), .IMR(IMR),
      .Read_command(Read_command), .DATA_OUT(DATA_OUT),
      .ICWs_Flags(ICWs_Flags), .OCWs_Flags(OCWs_Flags),
      .D_OUT(D_OUT), .D_OE(D_OE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic       cs_n;
      logic       a0;
      logic [7:0] d;
      logic [3:0] icw;
      logic [2:0] ocw;
      logic [7:0] data;
   } vec_t;

   vec_t tbl[23];

   // Reference model: initialization tracked as a queue of ICW numbers still owed.
   int         pending[$];
   bit         inited;
   logic [7:0] m_data;

   task automatic model_reset();
      pending.delete();
      inited = 0;
      m_data = 8'h00;
   endtask

   task automatic model_write(input logic cs_n, input logic a0, input logic [7:0] d,
                              output logic [3:0] icw, output logic [2:0] ocw);
      icw = 4'h0;
      ocw = 3'h0;
      if (!cs_n) begin
         if (!a0 && d[4]) begin
            icw = 4'b0001;
            pending.delete();
            pending.push_back(2);
            if (!d[1]) pending.push_back(3);
            if (d[0])  pending.push_back(4);
            inited = 1;
         end else if (pending.size() != 0) begin
            if (a0) begin
               int n;
               n = pending.pop_front();
               icw = 4'(1 << (n - 1));
            end
         end else if (inited) begin
            if (a0)                ocw = 3'b001;
            else if (d[4:3] == 2'b00) ocw = 3'b010;
            else if (d[4:3] == 2'b01) ocw = 3'b100;
         end
         if (icw != 0 || ocw != 0) m_data = d;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; WR_n = 1'b1; CS_n = 1'b1; RD_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   // Drives one write and watches 6 cycles after WR_n rises.
   task automatic do_write(input logic cs_n, input logic a0, input logic [7:0] d,
                           output logic [3:0] icw_or, output logic [2:0] ocw_or,
                           output int pos, output int cnt, output bit multi);
      icw_or = 0; ocw_or = 0; pos = 0; cnt = 0; multi = 0;
      @(negedge clk);
      CS_n = cs_n; A0 = a0; D_IN = d; WR_n = 1'b0;
      repeat (3) @(negedge clk);
      WR_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         icw_or |= ICWs_Flags;
         ocw_or |= OCWs_Flags;
         if ((|ICWs_Flags) || (|OCWs_Flags)) begin
            cnt++;
            if (pos == 0) pos = k;
         end
         if ($countones({ICWs_Flags, OCWs_Flags}) > 1) multi = 1;
      end
      CS_n = 1'b1;
   endtask

   task automatic check_write(input string name, input logic cs_n, input logic a0,
                              input logic [7:0] d, input logic [3:0] e_icw,
                              input logic [2:0] e_ocw, input logic [7:0] e_data);
      logic [3:0] icw_or;
      logic [2:0] ocw_or;
      int pos, cnt;
      bit multi;
      int e_pos, e_cnt;
      do_write(cs_n, a0, d, icw_or, ocw_or, pos, cnt, multi);
      e_pos = ((e_icw != 0) || (e_ocw != 0)) ? 3 : 0;
      e_cnt = (e_pos != 0) ? 1 : 0;
      check({name, " flags"}, {25'd0, ocw_or, icw_or}, {25'd0, e_ocw, e_icw});
      check({name, " timing"}, {pos[7:0], cnt[7:0], 7'd0, multi},
            {e_pos[7:0], e_cnt[7:0], 8'd0});
      check({name, " data"}, {24'd0, DATA_OUT}, {24'd0, e_data});
   endtask

   task automatic check_read(input string name, input logic cs_n, input logic rd_n,
                             input logic a0, input logic [7:0] e_dout, input logic e_oe);
      @(negedge clk);
      CS_n = cs_n; RD_n = rd_n; A0 = a0;
      #1;
      check({name, " read"}, {23'd0, D_OE, D_OUT}, {23'd0, e_oe, e_dout});
      @(negedge clk);
      check({name, " noflag"}, {25'd0, OCWs_Flags, ICWs_Flags}, 32'd0);
      RD_n = 1'b1; CS_n = 1'b1;
   endtask

   initial begin
      logic [3:0] e_icw;
      logic [2:0] e_ocw;
      logic [7:0] e_dout;

      tbl[0]  = '{1'b0, 1'b1, 8'h55, 4'h0, 3'h0, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 8'h13, 4'h0, 3'h0, 8'h00};
      tbl[2]  = '{1'b0, 1'b0, 8'h13, 4'h1, 3'h0, 8'h13};
      tbl[3]  = '{1'b0, 1'b1, 8'h20, 4'h2, 3'h0, 8'h20};
      tbl[4]  = '{1'b0, 1'b1, 8'h01, 4'h8, 3'h0, 8'h01};
      tbl[5]  = '{1'b0, 1'b1, 8'hFB, 4'h0, 3'h1, 8'hFB};
      tbl[6]  = '{1'b0, 1'b0, 8'h0B, 4'h0, 3'h4, 8'h0B};
      tbl[7]  = '{1'b0, 1'b0, 8'h20, 4'h0, 3'h2, 8'h20};
      tbl[8]  = '{1'b0, 1'b0, 8'h11, 4'h1, 3'h0, 8'h11};
      tbl[9]  = '{1'b0, 1'b1, 8'h40, 4'h2, 3'h0, 8'h40};
      tbl[10] = '{1'b0, 1'b1, 8'h04, 4'h4, 3'h0, 8'h04};
      tbl[11] = '{1'b0, 1'b1, 8'h03, 4'h8, 3'h0, 8'h03};
      tbl[12] = '{1'b0, 1'b1, 8'hFF, 4'h0, 3'h1, 8'hFF};
      tbl[13] = '{1'b0, 1'b0, 8'h13, 4'h1, 3'h0, 8'h13};
      tbl[14] = '{1'b0, 1'b1, 8'h20, 4'h2, 3'h0, 8'h20};
      tbl[15] = '{1'b0, 1'b0, 8'h12, 4'h1, 3'h0, 8'h12};
      tbl[16] = '{1'b0, 1'b1, 8'h20, 4'h2, 3'h0, 8'h20};
      tbl[17] = '{1'b0, 1'b1, 8'hAA, 4'h0, 3'h1, 8'hAA};
      tbl[18] = '{1'b0, 1'b0, 8'h13, 4'h1, 3'h0, 8'h13};
      tbl[19] = '{1'b0, 1'b0, 8'h08, 4'h0, 3'h0, 8'h13};
      tbl[20] = '{1'b1, 1'b1, 8'h77, 4'h0, 3'h0, 8'h13};
      tbl[21] = '{1'b0, 1'b1, 8'h20, 4'h2, 3'h0, 8'h20};
      tbl[22] = '{1'b0, 1'b1, 8'h01, 4'h8, 3'h0, 8'h01};

      rst_n = 1'b0; CS_n = 1'b1; WR_n = 1'b1; RD_n = 1'b1; A0 = 1'b0;
      D_IN = 8'h00; IRR = 8'h00; ISR = 8'h00; IMR = 8'h00; Read_command = 2'b00;
      do_reset();
      check("reset state", {9'd0, DATA_OUT, ICWs_Flags, OCWs_Flags, D_OE, D_OUT}, 32'd0);

      foreach (tbl[i])
         check_write($sformatf("vec%0d", i), tbl[i].cs_n, tbl[i].a0, tbl[i].d,
                     tbl[i].icw, tbl[i].ocw, tbl[i].data);

      // Readback in READY after OCW3.
      check_write("ocw3 before read", 1'b0, 1'b0, 8'h0B, 4'h0, 3'h4, 8'h0B);
      IRR = 8'hA0; ISR = 8'h04; IMR = 8'h81; Read_command = 2'b11;
      check_read("isr",   1'b0, 1'b0, 1'b0, 8'h04, 1'b1);
      check_read("imr",   1'b0, 1'b0, 1'b1, 8'h81, 1'b1);
      check_read("rd idle", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check_read("cs idle", 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
      Read_command = 2'b10;
      check_read("irr",   1'b0, 1'b0, 1'b0, 8'hA0, 1'b1);
      check_write("ocw1 after read", 1'b0, 1'b1, 8'h3C, 4'h0, 3'h1, 8'h3C);

      // Async reset between ICW2 and ICW4.
      do_reset();
      check_write("r38 icw1", 1'b0, 1'b0, 8'h13, 4'h1, 3'h0, 8'h13);
      check_write("r38 icw2", 1'b0, 1'b1, 8'h20, 4'h2, 3'h0, 8'h20);
      #3 rst_n = 1'b0;
      #1 check("async reset outs", {17'd0, DATA_OUT, ICWs_Flags, OCWs_Flags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check_write("r38 post a0=1", 1'b0, 1'b1, 8'h01, 4'h0, 3'h0, 8'h00);
      check_write("r38 reinit", 1'b0, 1'b0, 8'h13, 4'h1, 3'h0, 8'h13);

      // Write in flight when reset asserts is dropped.
      @(negedge clk);
      CS_n = 1'b0; A0 = 1'b1; D_IN = 8'h20; WR_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      WR_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      e_icw = 0; e_ocw = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         e_icw |= ICWs_Flags;
         e_ocw |= OCWs_Flags;
      end
      check("lost write", {17'd0, DATA_OUT, e_icw, e_ocw}, 32'd0);
      CS_n = 1'b1;

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            logic       r_cs, r_a0;
            logic [7:0] r_d;
            r_cs = ($urandom_range(0, 9) == 0);
            r_a0 = 1'($urandom);
            r_d  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
               r_a0 = 1'b0;
               r_d[4] = 1'b1;
            end
            model_write(r_cs, r_a0, r_d, e_icw, e_ocw);
            check_write($sformatf("rand%0d", n), r_cs, r_a0, r_d, e_icw, e_ocw, m_data);
         end else begin
            logic r_cs, r_rd, r_a0;
            IRR = 8'($urandom); ISR = 8'($urandom); IMR = 8'($urandom);
            Read_command = 2'($urandom);
            r_cs = 1'($urandom); r_rd = 1'($urandom); r_a0 = 1'($urandom);
            if (r_cs || r_rd)           e_dout = 8'h00;
            else if (r_a0)              e_dout = IMR;
            else if (Read_command == 3) e_dout = ISR;
            else                        e_dout = IRR;
            check_read($sformatf("rand%0d", n), r_cs, r_rd, r_a0, e_dout, !r_cs && !r_rd);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/read_write_logic.md
READ_WRITE_LOGIC -- requirements
Module: read_write_logic

Interface
REQ-001 SHALL: clk  input  1  single block clock; all state updates on its rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: CS_n  input  1  chip select, active-low, asynchronous to clk.
REQ-004 SHALL: WR_n  input  1  write strobe, active-low, asynchronous to clk.
REQ-005 SHALL: RD_n  input  1  read strobe, active-low.
REQ-006 SHALL: A0  input  1  port address bit.
REQ-007 SHALL: D_IN  input  8  CPU data bus, write direction.
REQ-008 SHALL: IRR, ISR, IMR  input  8 each  interrupt request, in-service and mask registers, for readback.
REQ-009 SHALL: Read_command  input  2  from control logic; 2'b11 selects ISR, any other value selects IRR.
REQ-010 SHALL: DATA_OUT  output  8  last accepted write byte, feeds control logic DATA_IN.
REQ-011 SHALL: ICWs_Flags  output  4  one-cycle pulses; bits 0..3 = ICW1..ICW4 received.
REQ-012 SHALL: OCWs_Flags  output  3  one-cycle pulses; bits 0..2 = OCW1..OCW3 received.
REQ-013 SHALL: D_OUT  output  8  CPU readback data; D_OE  output  1  read drive enable.

Function
REQ-014 SHALL: WR_n pass through a 2-flop synchronizer; a write is accepted on the synchronized 0->1 edge.
REQ-015 SHALL: while synchronized WR is low, capture CS_n, A0 and D_IN every cycle; the last capture before the edge is the write.
REQ-016 SHALL: a write whose captured CS_n = 1 is discarded: no flag, DATA_OUT unchanged.
REQ-017 SHALL: on an accepted write, DATA_OUT loads the captured byte and exactly one flag bit pulses high for one cycle, asserted on the 3rd rising clk edge after WR_n rises; at most one flag bit is high in any cycle.
REQ-018 SHALL: decode FSM states UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
REQ-019 SHALL: A0=0 with D[4]=1 is ICW1 in every state; it pulses ICW1, latches SNGL=D[1] and IC4=D[0], and goes to WAIT_ICW2 (restarts any init in progress).
REQ-020 SHALL: WAIT_ICW2 with A0=1 pulses ICW2; next state is WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
REQ-021 SHALL: WAIT_ICW3 with A0=1 pulses ICW3; next state is WAIT_ICW4 if IC4=1, else READY.
REQ-022 SHALL: WAIT_ICW4 with A0=1 pulses ICW4; next state is READY.
REQ-023 SHALL: in READY, A0=1 pulses OCW1; A0=0, D[4:3]=00 pulses OCW2; A0=0, D[4:3]=01 pulses OCW3.
REQ-024 SHALL: any other write (non-ICW1 in UNINIT or WAIT_*, A0=0 with D[4:3]=01 in WAIT_*, etc.) is ignored: no flag, DATA_OUT unchanged, state unchanged.
REQ-025 SHALL: D_OE = !CS_n & !RD_n, combinational.
REQ-026 SHALL: D_OUT = IMR when A0=1; when A0=0, D_OUT = ISR if Read_command = 2'b11, else IRR.
REQ-027 SHALL: D_OUT is 8'h00 when D_OE = 0.
REQ-028 SHALL: a read does not alter FSM state or flags.

Reset
REQ-029 SHALL: rst_n low asynchronously forces FSM = UNINIT, SNGL = 0, IC4 = 0, DATA_OUT = 8'h00, all flags = 0, synchronizer flops = 1 (WR idle), capture registers = 0.
REQ-030 SHALL: a write in progress when reset asserts is lost and produces no flag after release.

Structure
REQ-031 SHALL: FSM state encoding, flag bit indices and Read_command codes live in shared package pic_pkg.
REQ-032 SHALL: the synchronizer and rise detector be one sub-module, sync_rise (parameterless, 1-bit).

Verification
REQ-033 SHALL: writes ICW1=0x13 (A0=0), ICW2=0x20, ICW4=0x01, OCW1=0xFB -> pulses ICWs_Flags 0001, 0010, 1000, then OCWs_Flags 001; DATA_OUT ends 0xFB; no ICW3 pulse.
REQ-034 SHALL: cascade init ICW1=0x11, ICW2=0x40, ICW3=0x04, ICW4=0x03 -> ICW1, ICW2, ICW3, ICW4 pulses in order; FSM READY.
REQ-035 SHALL: OCW1=0x55 after reset and before any ICW1 -> no flag, DATA_OUT stays 0x00; write with CS_n=1 -> no flag.
REQ-036 SHALL: ICW1=0x13, ICW2=0x20, then ICW1=0x12 -> second ICW1 pulse; a following A0=1 write pulses ICW2, then FSM READY (IC4=0).
REQ-037 SHALL: in READY, OCW3=0x0B, then IRR=0xA0, ISR=0x04, IMR=0x81 with Read_command=11: RD A0=0 -> D_OUT=0x04, RD A0=1 -> D_OUT=0x81, RD_n high -> D_OE=0, D_OUT=0x00.
REQ-038 SHALL: rst_n pulsed low between ICW2 and ICW4 -> all outputs 0, FSM UNINIT; the next A0=1 write produces no flag.
